// File: rtl/alu_regfile_sequencer_if.sv
// alu_regfile_sequencer_if: command/response handshake bundle between a requester and the sequencer.
interface alu_regfile_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_kind;
    logic [3:0]        cmd_opcode;
    logic [1:0]        cmd_mode;
    logic [4:0]        cmd_shamt;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic [ADDR_W-1:0] cmd_rd;
    logic [DATA_W-1:0] cmd_imm;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_result;
    logic [1:0]        rsp_overflow;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_kind, cmd_opcode, cmd_mode, cmd_shamt,
               cmd_rs1, cmd_rs2, cmd_rd, cmd_imm,
        input  cmd_ready, rsp_valid, rsp_result, rsp_overflow, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_opcode, cmd_mode, cmd_shamt,
               cmd_rs1, cmd_rs2, cmd_rd, cmd_imm,
        output cmd_ready, rsp_valid, rsp_result, rsp_overflow, rsp_err
    );
endinterface

// File: rtl/alu_regfile_sequencer.sv
// alu_regfile_sequencer: one-command-at-a-time front end driving the shared ALU + register file.
// OVF_TRAP_EN: suppresses writeback of signed-overflowing ALU results and adds a sticky ovf_trap output.
module alu_regfile_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int MAX_OP = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_regfile_sequencer_if.slave bus,
    output logic [ADDR_W-1:0]     readreg1,
    output logic [ADDR_W-1:0]     readreg2,
    output logic [ADDR_W-1:0]     writereg,
    output logic [DATA_W-1:0]     data_in,
    output logic                  mux_ctrl,
    output logic                  write_enable,
    output logic [3:0]            OpCode,
    output logic [1:0]            Mode,
    output logic [4:0]            Shift_amt,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [1:0]            alu_overflow,
`ifdef OVF_TRAP_EN
    output logic                  ovf_trap,
`endif
    output logic [CNT_W-1:0]      op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

    localparam logic [3:0] MAX_OPC = 4'(MAX_OP);

    state_t            state_q, state_d;
    logic              kind_q, kind_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] readreg1_q, readreg1_d;
    logic [ADDR_W-1:0] readreg2_q, readreg2_d;
    logic [ADDR_W-1:0] writereg_q, writereg_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [1:0]        mode_q, mode_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [1:0]        rsp_overflow_q, rsp_overflow_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic              legal;
    logic              trap;
`ifdef OVF_TRAP_EN
    logic              ovf_trap_q, ovf_trap_d;
    assign trap = kind_q && mode_q == 2'd1 && |rsp_overflow_q;
`else
    assign trap = 1'b0;
`endif

    assign legal = bus.cmd_opcode <= MAX_OPC;

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        err_d          = err_q;
        rd_d           = rd_q;
        imm_d          = imm_q;
        readreg1_d     = readreg1_q;
        readreg2_d     = readreg2_q;
        writereg_d     = writereg_q;
        data_in_d      = data_in_q;
        opcode_d       = opcode_q;
        mode_d         = mode_q;
        shamt_d        = shamt_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        op_count_d     = op_count_q;
`ifdef OVF_TRAP_EN
        ovf_trap_d     = ovf_trap_q;
`endif
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                kind_d = bus.cmd_kind;
                err_d  = bus.cmd_kind && !legal;
                rd_d   = bus.cmd_rd;
                imm_d  = bus.cmd_imm;
                if (!bus.cmd_kind) begin
                    state_d        = WB;
                    writereg_d     = bus.cmd_rd;
                    data_in_d      = bus.cmd_imm;
                    rsp_result_d   = bus.cmd_imm;
                    rsp_overflow_d = '0;
                end else if (legal) begin
                    state_d    = EXEC;
                    readreg1_d = bus.cmd_rs1;
                    readreg2_d = bus.cmd_rs2;
                    opcode_d   = bus.cmd_opcode;
                    mode_d     = bus.cmd_mode;
                    shamt_d    = bus.cmd_shamt;
                end else begin
                    state_d        = RESP;
                    rsp_result_d   = '0;
                    rsp_overflow_d = '0;
                end
            end
            EXEC: begin
                state_d        = WB;
                writereg_d     = rd_q;
                rsp_result_d   = alu_result;
                rsp_overflow_d = alu_overflow;
            end
            WB: state_d = RESP;
            RESP: begin
                state_d    = IDLE;
                op_count_d = op_count_q + 1'b1;
`ifdef OVF_TRAP_EN
                ovf_trap_d = ovf_trap_q | trap;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            kind_q         <= 1'b0;
            err_q          <= 1'b0;
            rd_q           <= '0;
            imm_q          <= '0;
            readreg1_q     <= '0;
            readreg2_q     <= '0;
            writereg_q     <= '0;
            data_in_q      <= '0;
            opcode_q       <= '0;
            mode_q         <= '0;
            shamt_q        <= '0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= '0;
            op_count_q     <= '0;
`ifdef OVF_TRAP_EN
            ovf_trap_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            err_q          <= err_d;
            rd_q           <= rd_d;
            imm_q          <= imm_d;
            readreg1_q     <= readreg1_d;
            readreg2_q     <= readreg2_d;
            writereg_q     <= writereg_d;
            data_in_q      <= data_in_d;
            opcode_q       <= opcode_d;
            mode_q         <= mode_d;
            shamt_q        <= shamt_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            op_count_q     <= op_count_d;
`ifdef OVF_TRAP_EN
            ovf_trap_q     <= ovf_trap_d;
`endif
        end
    end

    assign bus.cmd_ready    = state_q == IDLE;
    assign bus.rsp_valid    = state_q == RESP;
    assign bus.rsp_err      = state_q == RESP && err_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign readreg1         = readreg1_q;
    assign readreg2         = readreg2_q;
    assign writereg         = writereg_q;
    assign data_in          = data_in_q;
    assign OpCode           = opcode_q;
    assign Mode             = mode_q;
    assign Shift_amt        = shamt_q;
    assign mux_ctrl         = state_q == WB && kind_q;
    assign write_enable     = state_q == WB && !trap;
    assign op_count         = op_count_q;
`ifdef OVF_TRAP_EN
    assign ovf_trap         = ovf_trap_q;
`endif
endmodule

// File: tb/tb_alu_regfile_sequencer.sv
// tb_alu_regfile_sequencer: table-driven bench with a regfile/ALU environment model and response scoreboard.
module tb_alu_regfile_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  readreg1, readreg2, writereg;
    logic [31:0] data_in;
    logic        mux_ctrl, write_enable;
    logic [3:0]  OpCode;
    logic [1:0]  Mode;
    logic [4:0]  Shift_amt;
    logic [31:0] alu_res;
    logic [1:0]  alu_ovf;
    logic [15:0] op_count;
`ifdef OVF_TRAP_EN
    logic        ovf_trap;
`endif

    always #5 clk = ~clk;

    alu_regfile_sequencer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    alu_regfile_sequencer #(.DATA_W(32), .ADDR_W(5), .MAX_OP(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .readreg1(readreg1), .readreg2(readreg2), .writereg(writereg),
        .data_in(data_in), .mux_ctrl(mux_ctrl), .write_enable(write_enable),
        .OpCode(OpCode), .Mode(Mode), .Shift_amt(Shift_amt),
        .alu_result(alu_res), .alu_overflow(alu_ovf),
`ifdef OVF_TRAP_EN
        .ovf_trap(ovf_trap),
`endif
        .op_count(op_count)
    );

    // Environment: register file plus ALU; overflow bit0 = signed overflow (Mode 1), bit1 = carry/borrow (Mode 0)
    logic [31:0] regs [32] = '{default: 32'h0};
    logic [31:0] a, b;
    logic [32:0] sum;
    always_comb begin
        a = regs[readreg1];
        b = regs[readreg2];
        sum = '0;
        alu_res = '0;
        alu_ovf = '0;
        case (OpCode)
            4'd0: begin
                sum = {1'b0, a} + {1'b0, b};
                alu_res = sum[31:0];
                alu_ovf = (Mode == 2'd1) ? {1'b0, a[31] == b[31] && alu_res[31] != a[31]} : {sum[32], 1'b0};
            end
            4'd1: begin
                sum = {1'b0, a} - {1'b0, b};
                alu_res = sum[31:0];
                alu_ovf = (Mode == 2'd1) ? {1'b0, a[31] != b[31] && alu_res[31] != a[31]} : {sum[32], 1'b0};
            end
            4'd2: alu_res = a & b;
            4'd3: alu_res = a | b;
            4'd4: alu_res = a << Shift_amt;
            4'd5: alu_res = a >> Shift_amt;
            4'd6: alu_res = $signed(a) >>> Shift_amt;
            4'd7: alu_res = {31'b0, (Mode == 2'd1) ? $signed(a) > $signed(b) : a > b};
            4'd8: alu_res = {31'b0, (Mode == 2'd1) ? $signed(a) < $signed(b) : a < b};
            default: alu_res = '0;
        endcase
    end
    always @(posedge clk) if (write_enable) regs[writereg] <= mux_ctrl ? alu_res : data_in;

    typedef struct {
        logic        kind;
        logic [3:0]  op;
        logic [1:0]  mode;
        logic [4:0]  sh, rs1, rs2, rd;
        logic [31:0] imm, res;
        logic [1:0]  ovf;
        logic        err;
        int          we;
    } vec_t;
    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    exp_t q[$];
    vec_t vt[12];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, acc_cnt = 0, we_cnt = 0;
`ifdef OVF_TRAP_EN
    localparam int ADD_WE = 0;
`else
    localparam int ADD_WE = 1;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.cmd_valid && bus.cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (write_enable) begin
                we_cnt++;
                chk("wb_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("wb_writereg", writereg, q[0].v.rd);
                    chk("wb_mux_ctrl", mux_ctrl, q[0].v.kind);
                    if (q[0].v.kind) begin
                        chk("wb_readreg1", readreg1, q[0].v.rs1);
                        chk("wb_readreg2", readreg2, q[0].v.rs2);
                        chk("wb_opcode", OpCode, q[0].v.op);
                    end else chk("wb_data_in", data_in, q[0].v.imm);
                end
            end
            if (bus.rsp_valid) begin
                chk("rsp_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rsp_result", bus.rsp_result, e.v.res);
                    chk("rsp_overflow", bus.rsp_overflow, e.v.ovf);
                    chk("rsp_err", bus.rsp_err, e.v.err);
                    chk("write_count", we_cnt, e.v.we);
                    chk("latency", cyc - e.acc, e.v.err ? 1 : (e.v.kind ? 3 : 2));
                    chk("ready_in_resp", bus.cmd_ready, 0);
                end
                we_cnt = 0;
            end
        end
    end

    // Leaves cmd_valid high so a following send keeps it asserted through the busy cycles
    task automatic send(input vec_t v);
        int t = 0;
        bus.cmd_kind = v.kind;
        bus.cmd_opcode = v.op;
        bus.cmd_mode = v.mode;
        bus.cmd_shamt = v.sh;
        bus.cmd_rs1 = v.rs1;
        bus.cmd_rs2 = v.rs2;
        bus.cmd_rd = v.rd;
        bus.cmd_imm = v.imm;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", t < 20, 1);
        if (t < 20) begin
            q.push_back('{v, cyc});
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int t = 0;
        bus.cmd_valid = 1'b0;
        while (q.size() > 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) send(vt[i]);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, required $finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int t;
        int rsp_seen;
        vec_t v;
        //         kind  op     mode  sh    rs1    rs2    rd     imm            res            ovf   err  we
        vt[0]  = '{1'b0, 4'd0,  2'd0, 5'd0, 5'd0,  5'd0,  5'd17, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'd0, 1'b0, 1};
        vt[1]  = '{1'b0, 4'd0,  2'd0, 5'd0, 5'd0,  5'd0,  5'd18, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'd0, 1'b0, 1};
        vt[2]  = '{1'b1, 4'd0,  2'd1, 5'd0, 5'd17, 5'd18, 5'd31, 32'h0,        32'hFFFFFFFE, 2'd1, 1'b0, ADD_WE};
        vt[3]  = '{1'b0, 4'd0,  2'd0, 5'd0, 5'd0,  5'd0,  5'd5,  32'd505,      32'd505,      2'd0, 1'b0, 1};
        vt[4]  = '{1'b0, 4'd0,  2'd0, 5'd0, 5'd0,  5'd0,  5'd20, 32'hFFFF0218, 32'hFFFF0218, 2'd0, 1'b0, 1};
        vt[5]  = '{1'b1, 4'd1,  2'd1, 5'd0, 5'd5,  5'd20, 5'd5,  32'h0,        32'd65505,    2'd0, 1'b0, 1};
        vt[6]  = '{1'b1, 4'd6,  2'd1, 5'd5, 5'd20, 5'd0,  5'd1,  32'h0,        32'hFFFFF810, 2'd0, 1'b0, 1};
        vt[7]  = '{1'b1, 4'd8,  2'd1, 5'd0, 5'd20, 5'd1,  5'd2,  32'h0,        32'h1,        2'd0, 1'b0, 1};
        vt[8]  = '{1'b1, 4'd12, 2'd0, 5'd0, 5'd1,  5'd2,  5'd3,  32'h0,        32'h0,        2'd0, 1'b1, 0};
        vt[9]  = '{1'b1, 4'd2,  2'd0, 5'd0, 5'd17, 5'd20, 5'd3,  32'h0,        32'h7FFF0218, 2'd0, 1'b0, 1};
        vt[10] = '{1'b1, 4'd0,  2'd0, 5'd0, 5'd17, 5'd20, 5'd4,  32'h0,        32'h7FFF0217, 2'd2, 1'b0, 1};
        vt[11] = '{1'b1, 4'd9,  2'd1, 5'd0, 5'd1,  5'd2,  5'd6,  32'h0,        32'h0,        2'd0, 1'b1, 0};
        bus.cmd_valid = 1'b0;
        bus.cmd_kind = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_mode = '0;
        bus.cmd_shamt = '0;
        bus.cmd_rs1 = '0;
        bus.cmd_rs2 = '0;
        bus.cmd_rd = '0;
        bus.cmd_imm = '0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", bus.cmd_ready, 1);
        chk("reset_write_enable", write_enable, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_op_count", op_count, 0);
        chk("reset_readreg1", readreg1, 0);
        chk("reset_mux_ctrl", mux_ctrl, 0);
        chk("reset_rsp_result", bus.rsp_result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 2);
        chk("op_count_after_loads", op_count, 2);
        run(2, 12);
        chk("op_count_after_table", op_count, 12);
        chk("accept_count", acc_cnt, 12);
        chk("r5_after_sub", regs[5], 32'd65505);
        chk("r1_after_sra", regs[1], 32'hFFFFF810);
        chk("r2_after_lt", regs[2], 32'h1);
        chk("r4_after_add_u", regs[4], 32'h7FFF0217);
`ifdef OVF_TRAP_EN
        chk("ovf_trap_set", ovf_trap, 1);
        chk("r31_untouched", regs[31], 32'h0);
`else
        chk("r31_after_add", regs[31], 32'hFFFFFFFE);
`endif

        // Abort during writeback: reset lands while write_enable is high
        v = '{1'b0, 4'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd9, 32'hDEAD, 32'hDEAD, 2'd0, 1'b0, 1};
        send(v);
        t = 0;
        while (!write_enable && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("reached_wb", write_enable, 1);
        #1;
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        q.delete();
        we_cnt = 0;
        chk("abort_write_enable", write_enable, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_op_count", op_count, 0);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
`ifdef OVF_TRAP_EN
        chk("abort_ovf_trap", ovf_trap, 0);
`endif
        rst_n = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen++;
        end
        chk("abort_no_rsp", rsp_seen, 0);

        v = '{1'b0, 4'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd9, 32'h1234, 32'h1234, 2'd0, 1'b0, 1};
        send(v);
        drain();
        chk("recover_op_count", op_count, 1);
        chk("recover_r9", regs[9], 32'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_regfile_sequencer.md
Name: alu_regfile_sequencer

Overview:
- Command-driven controller that sequences the shared ALU + register-file datapath (`Alu_plus_regfile`).
- Accepts one command at a time over valid/ready: either a LOAD (immediate to register) or an ALU op (rs1 op rs2 -> rd).
- Drives regfile addresses, write mux, write enable, ALU OpCode/Mode/Shift_amt; captures Result/Overflow; writes back; reports completion.
- Replaces the hand-sequenced bench stimulus with a reusable front end.

Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width (32 registers)
- MAX_OP, 8, highest legal ALU OpCode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 GT, 8 LT)
- CNT_W, 16, completed-command counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset: synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_kind  in  1  0 = LOAD, 1 = ALU
- cmd_opcode  in  4  ALU OpCode
- cmd_mode  in  2  ALU Mode (0 unsigned, 1 signed)
- cmd_shamt  in  5  shift amount
- cmd_rs1, cmd_rs2, cmd_rd  in  ADDR_W each  source/destination registers
- cmd_imm  in  DATA_W  LOAD data
- readreg1, readreg2, writereg  out  ADDR_W each  to regfile
- data_in  out  DATA_W  to regfile write mux (external data path)
- mux_ctrl  out  1  0 = write data_in, 1 = write ALU Result
- write_enable  out  1  regfile write strobe
- OpCode  out  4; Mode  out  2; Shift_amt  out  5  to ALU
- alu_result  in  DATA_W  ALU Result
- alu_overflow  in  2  ALU Overflow
- rsp_valid  out  1  one-cycle completion pulse
- rsp_result  out  DATA_W  value written (or would have been written)
- rsp_overflow  out  2  captured Overflow
- rsp_err  out  1  illegal opcode, valid with rsp_valid
- op_count  out  CNT_W  completed commands, wraps at 2^CNT_W

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; every output 0 except cmd_ready=1; op_count=0; all command registers cleared. Reset mid-operation aborts; write_enable is 0 from the next cycle and no writeback occurs.
- FSM: IDLE, EXEC, WB, RESP.
- IDLE:
  - cmd_ready=1.
  - Handshake is cmd_valid & cmd_ready at the edge: latch all cmd_* fields.
  - kind=ALU with opcode <= MAX_OP -> EXEC.
  - kind=LOAD -> WB.
  - kind=ALU with opcode > MAX_OP -> RESP with rsp_err=1 and no write.
- EXEC (1 cycle):
  - Drive readreg1/2, OpCode, Mode, Shift_amt from the latched command; write_enable=0.
  - At the edge, capture alu_result/alu_overflow into rsp_result/rsp_overflow, then go to WB.
- WB (1 cycle):
  - Hold the EXEC drive values; writereg=rd; write_enable=1.
  - ALU: mux_ctrl=1. LOAD: mux_ctrl=0, data_in=imm, rsp_result=imm, rsp_overflow=0.
  - Next state RESP.
- RESP (1 cycle): rsp_valid=1; op_count increments (including error commands); next state IDLE.
- cmd_ready is 0 in all states except IDLE. Commands are never queued or dropped; the requester holds cmd_valid until the handshake.
- Latency: ALU accept at cycle 0 -> regfile written at end of cycle 2 -> rsp_valid in cycle 3; next accept in cycle 4. LOAD is one cycle shorter.
- Datapath controls (readreg*, OpCode, Mode, Shift_amt, writereg, data_in) hold their last values in IDLE/RESP. write_enable is high only in WB.
- rd = rs1 or rd = rs2 is legal: operands are read in EXEC, before the WB write.
- op_count wraps from all-ones to 0 with no flag.

Optional Feature:
- Macro OVF_TRAP_EN.
- Defined:
  - ALU command with nonzero captured overflow and Mode=1 suppresses the WB write (write_enable stays 0); rsp_valid still pulses.
  - Extra output ovf_trap (1 bit) sets sticky at that RESP; it clears only on reset.
- Undefined: overflow is reported only via rsp_overflow and the result is always written; ovf_trap port absent.

Test Plan:
- LOAD rd=17 imm=32'h7FFFFFFF, then LOAD rd=18 same -> write_enable pulses once each with mux_ctrl=0, rsp_valid each; op_count=2.
- ALU ADD Mode=1 rs1=17 rs2=18 rd=31 -> readreg1=17, readreg2=18 in EXEC; write to r31 with mux_ctrl=1 at cycle 2; rsp_overflow nonzero; rsp_valid at cycle 3. With OVF_TRAP_EN: no write, ovf_trap=1.
- LOAD r5=505, r20=-65000; SUB Mode=1 rs1=5 rs2=20 rd=5 -> rsp_result=65505; r5 reads 65505 afterward.
- SRA Mode=1 rs1=20 shamt=5 rd=1 -> rsp_result=-2032 (32'hFFFFF810); LT Mode=1 rs1=20 rs2=1 -> rsp_result=1.
- cmd_opcode=12 -> rsp_err=1, no write_enable pulse, op_count increments; cmd_valid held during busy -> exactly one accept per IDLE.
- rst_n=0 asserted during WB -> next cycle write_enable=0, cmd_ready=1, op_count=0, rsp_valid never pulses.
